// File: rtl/msj_display_pkg.sv
// Shared types and constants for the maintenance message display: FSM states,
// the reserved alarm code and the active-low 7-segment patterns {g,f,e,d,c,b,a}.
package msj_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_CODE = 8'hFF;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/msj_display_bin2bcd.sv
// Sequential double-dabble converter: start pulse in IDLE -> LOAD -> 8x SHIFT -> DONE.
// busy is registered; done is a one-cycle strobe while in DONE; state is exported for checkers.
module bin2bcd_seq
  import msj_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic [7:0] captured,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       busy,
  output logic       done,
  output state_t     state
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [19:0] sh_q;    // {hundreds, tens, units, binary}
  logic [19:0] adj;
  logic [7:0]  cap_q;
  logic        busy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd1) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adj = sh_q;
    if (sh_q[11:8]  >= 4'd5) adj[11:8]  = sh_q[11:8]  + 4'd3;
    if (sh_q[15:12] >= 4'd5) adj[15:12] = sh_q[15:12] + 4'd3;
    if (sh_q[19:16] >= 4'd5) adj[19:16] = sh_q[19:16] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 20'd0;
      cap_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == LOAD) || (state_d == SHIFT);
      if (state_q == LOAD) begin
        cap_q <= bin;
        sh_q  <= {12'd0, bin};
        cnt_q <= 4'd8;
      end else if (state_q == SHIFT) begin
        sh_q  <= {adj[18:0], 1'b0};
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign captured = cap_q;
  assign hundreds = sh_q[19:16];
  assign tens     = sh_q[15:12];
  assign units    = sh_q[11:8];
  assign busy     = busy_q;
  assign done     = (state_q == DONE);
  assign state    = state_q;

endmodule

// File: rtl/msj_display.sv
// Display stage for the maintenance message: change detection, alarm flag with blink,
// leading-zero blanking and a 3-digit multiplexed active-low 7-segment scan.
module msj_display
  import msj_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] msj_in,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       conv_busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t      fsm_state;
  logic [7:0]  captured;
  logic [3:0]  bcd_h, bcd_t, bcd_u;
  logic        conv_done;
  logic        start, set_alarm, is_idle;

  logic          valid_q, valid_d;
  logic          alarm_q, alarm_d;
  logic          blink_off_q, blink_off_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    disp_h_q, disp_t_q, disp_u_q;
  logic [3:0]    disp_h_d, disp_t_d, disp_u_d;
  logic [6:0]    seg_d;
  logic [2:0]    an_d;

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (msj_in),
    .captured (captured),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u),
    .busy     (conv_busy),
    .done     (conv_done),
    .state    (fsm_state)
  );

  // Alarm is taken whenever FF is present in IDLE; counts convert only on change
  // (or unconditionally while no valid value is held).
  always_comb begin
    is_idle   = (fsm_state == IDLE);
    set_alarm = is_idle && (msj_in == ALARM_CODE);
    start     = is_idle && (msj_in != ALARM_CODE) && (!valid_q || (msj_in != captured));
  end

  always_comb begin
    alarm_d = alarm_q;
    if (set_alarm)  alarm_d = 1'b1;
    else if (start) alarm_d = 1'b0;

    valid_d = valid_q;
    if (set_alarm)      valid_d = 1'b0;
    else if (conv_done) valid_d = 1'b1;

    disp_h_d = disp_h_q;
    disp_t_d = disp_t_q;
    disp_u_d = disp_u_q;
    if (conv_done) begin
      disp_h_d = bcd_h;
      disp_t_d = bcd_t;
      disp_u_d = bcd_u;
    end

    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (set_alarm && !alarm_q) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (alarm_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Segment mux works from next-cycle values so digit index and display regs change together.
  always_comb begin
    seg_d = SEG_BLANK;
    if (alarm_d) begin
      if (!blink_off_d) seg_d = (idx_d == 2'd2) ? SEG_E : SEG_R;
    end else if (valid_d) begin
      case (idx_d)
        2'd0:    seg_d = seg_of_digit(disp_u_d);
        2'd1:    seg_d = (disp_h_d == 4'd0 && disp_t_d == 4'd0) ? SEG_BLANK
                                                                : seg_of_digit(disp_t_d);
        default: seg_d = (disp_h_d == 4'd0) ? SEG_BLANK : seg_of_digit(disp_h_d);
      endcase
    end
    an_d = ~(3'b001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      alarm_q     <= 1'b0;
      blink_off_q <= 1'b0;
      ref_cnt_q   <= '0;
      blink_cnt_q <= '0;
      idx_q       <= 2'd0;
      disp_h_q    <= 4'd0;
      disp_t_q    <= 4'd0;
      disp_u_q    <= 4'd0;
      seg         <= SEG_BLANK;
      an          <= 3'b111;
    end else begin
      valid_q     <= valid_d;
      alarm_q     <= alarm_d;
      blink_off_q <= blink_off_d;
      ref_cnt_q   <= ref_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      disp_h_q    <= disp_h_d;
      disp_t_q    <= disp_t_d;
      disp_u_q    <= disp_u_d;
      seg         <= seg_d;
      an          <= an_d;
    end
  end

endmodule

// File: tb/tb_msj_display.sv
// Directed bench for msj_display: expected digit patterns are queued when a value is
// driven and popped/compared once the conversion lands on the scanned display.
module tb_msj_display;

  localparam int RD = 4;
  localparam int BD = 8;

  logic       clk;
  logic       rst;
  logic [7:0] msj_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       conv_busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [20:0] exp_q[$];   // {hundreds_seg, tens_seg, units_seg}

  msj_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .msj_in    (msj_in),
    .seg       (seg),
    .an        (an),
    .conv_busy (conv_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] dseg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h40; 1: s = 7'h79; 2: s = 7'h24; 3: s = 7'h30; 4: s = 7'h19;
      5: s = 7'h12; 6: s = 7'h02; 7: s = 7'h78; 8: s = 7'h00; 9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [20:0] model(input logic [7:0] v);
    int h, t, u;
    logic [6:0] hs, ts, us;
    h  = int'(v) / 100;
    t  = (int'(v) / 10) % 10;
    u  = int'(v) % 10;
    hs = (h == 0) ? 7'h7F : dseg(h);
    ts = (h == 0 && t == 0) ? 7'h7F : dseg(t);
    us = dseg(u);
    return {hs, ts, us};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input bit push);
    msj_in = v;
    if (push) exp_q.push_back(model(v));
  endtask

  task automatic wait_conv(input string tag, input bit chk_len);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (conv_busy !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    while (conv_busy === 1'b1 && guard < 100) begin
      n++;
      @(negedge clk);
      guard++;
    end
    if (chk_len) check({tag, "_busy_len"}, n, 9);
    else         check({tag, "_busy_seen"}, 32'((n > 0) && (guard < 100)), 1);
  endtask

  task automatic check_display(input string tag);
    logic [20:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1FFFFF;
    @(negedge clk);
    for (int k = 0; k < 3 * RD; k++) begin
      case (an)
        3'b110:  check({tag, "_units"},    seg, e[6:0]);
        3'b101:  check({tag, "_tens"},     seg, e[13:7]);
        3'b011:  check({tag, "_hundreds"}, seg, e[20:14]);
        default: check({tag, "_an"},       an,  3'b110);
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b0;
    msj_in = 8'd0;

    // Reset with 37 held, then release and convert
    drive(8'd37, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 3'b111);
    check("rst_busy", conv_busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_an", an, 3'b110);
    check("rel_busy", conv_busy, 1);
    wait_conv("c37", 1'b1);
    check_display("d37");

    // Change mid-conversion: 12 then 200 three cycles later
    drive(8'd12, 1'b0);
    repeat (3) @(negedge clk);
    drive(8'd200, 1'b1);
    wait_conv("c12", 1'b0);
    wait_conv("c200", 1'b1);
    check_display("d200");

    // Blanking boundaries
    drive(8'd0, 1'b1);
    wait_conv("c0", 1'b1);
    check_display("d0");
    drive(8'd100, 1'b1);
    wait_conv("c100", 1'b1);
    check_display("d100");
    drive(8'd254, 1'b1);
    wait_conv("c254", 1'b1);
    check_display("d254");

    // Same value again: no reconversion
    drive(8'd254, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("same_no_busy", conv_busy, 0);
    end

    // Alarm: blinking Err
    drive(8'hFF, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4 * BD; k++) begin
      logic [6:0] e;
      if (((k / BD) % 2) == 1) e = 7'h7F;
      else                     e = (an == 3'b011) ? 7'h06 : 7'h2F;
      check($sformatf("alarm_seg_k%0d", k), seg, e);
      check("alarm_busy", conv_busy, 0);
      @(negedge clk);
    end

    // Leave alarm: blank until the new conversion completes
    drive(8'd37, 1'b1);
    @(negedge clk);
    check("leave_blank", seg, 7'h7F);
    wait_conv("c37b", 1'b1);
    check_display("d37b");

    // Reset in the middle of a conversion
    drive(8'd77, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_an", an, 3'b111);
    check("mid_rst_busy", conv_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_an", an, 3'b110);
    check("mid_rel_busy", conv_busy, 1);
    wait_conv("c77", 1'b1);
    check_display("d77");

    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
